ldpc_bf_decoder: RTL and testbench
==================================

// Module: ldpc_bf_decoder
// PURPOSE
//  Hard-decision bit-flipping decoder for the team's quasi-cyclic LDPC code; receive-side counterpart of the LDPC encoder.
//  Takes one N-bit codeword per frame, iterates syndrome/flip until the syndrome is zero or MAX_ITER is reached.
//  Returns the K-bit systematic message, a success flag and the iteration count.
// PARAMETERS
//  Z         8   circulant size; N = NB*Z, M = MB*Z, K = N-M (NB, MB, shift table from ldpc_dec_pkg)
//  MAX_ITER  16  maximum flip iterations per frame (0 legal: syndrome check only)
//  ITW       5   width of iteration counter, must hold MAX_ITER
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    synchronous active-low reset
//  in_valid   in   1    codeword valid
//  in_ready   out  1    decoder can accept a codeword
//  c          in   N    received hard-decision codeword
//  out_valid  out  1    decoded result valid
//  out_ready  in   1    downstream accepts result
//  s          out  K    decoded message = corrected cw[N-1 -: K]
//  dec_ok     out  1    1 = final syndrome zero
//  iter_used  out  ITW  number of flip iterations performed
//  stat_frames out 16   [LDPC_DEC_STATS_EN only] frames completed
//  stat_fails  out 16   [LDPC_DEC_STATS_EN only] frames with dec_ok=0
// BEHAVIOUR
//  H: base block (r,b) with shift p>=0 links check r*Z+i to bit b*Z+((i+p) mod Z); p=-1 means zero block.
//  FSM: IDLE -> SYND -> EVAL -> (SYND | DONE) -> IDLE.
//  - IDLE: in_ready=1; on in_valid: cw_reg<=c, iter<=0, go SYND. in_ready=0 in every other state.
//  - SYND: syn_reg <= H*cw_reg (mod 2), go EVAL.
//  - EVAL: syn_reg==0 -> DONE, dec_ok<=1. Else iter==MAX_ITER -> DONE, dec_ok<=0.
//    Else per bit j: u_j = number of unsatisfied checks on j; umax = max u_j.
//    Flip every bit with u_j==umax; iter<=iter+1; go SYND.
//  - DONE: out_valid=1; s, dec_ok, iter_used stable while out_valid && !out_ready.
//    On out_ready go IDLE. New input is accepted only from IDLE, one cycle after the handshake.
//  Latency: the accept edge is edge 0. out_valid is high after edge 2+2*iter_used. A clean frame gives out_valid after edge 2.
//  Reset: out_valid=0, in_ready=1 (state IDLE), s=0, dec_ok=0, iter_used=0, syn_reg=0, stats=0.
//    A reset mid-frame discards the frame and produces no output.
//  Widths: u_j is $clog2(MB+1) bits; iter saturation is impossible because EVAL checks MAX_ITER before incrementing.
//  s/dec_ok/iter_used update only on the IDLE->...->DONE path and hold their values in IDLE until the next frame completes.
// CONFIGURATION
//  LDPC_DEC_STATS_EN defined:
//    stat_frames increments on each out_valid&&out_ready; stat_fails also increments when dec_ok=0.
//    Both counters wrap at 2^16 and are cleared by rst_n.
//  LDPC_DEC_STATS_EN undefined: stat ports and counters absent; everything else identical.
// STRUCTURE
//  ldpc_dec_pkg: NB=4, MB=2, shift table SHIFT[MB][NB] = {{0,0,0,0},{0,1,2,3}} (girth >= 6),
//    the -1 zero-block constant, and functions for N/M/K.
//  Sub-module ldpc_syndrome_calc (combinational):
//    cw[N-1:0] -> syndrome[M-1:0] and per-bit unsat counts, driven entirely by the package table.
//    The FSM, registers and handshake stay in ldpc_bf_decoder.
// TESTING (defaults Z=8, N=32, K=16)
//  1 c=32'h0, out_ready=1 -> out_valid after edge 2, s=16'h0000, dec_ok=1, iter_used=0.
//  2 c=32'h0000_0020 (bit 5 flipped) -> bit 5 has u=2, all others <=1.
//    Expect one flip, s=16'h0000, dec_ok=1, iter_used=1, out_valid after edge 4.
//  3 MAX_ITER=0, c=32'h0001_0000 -> dec_ok=0, iter_used=0, s=16'h0001 (raw bits).
//  4 out_ready low for 5 cycles in DONE -> out_valid, s, dec_ok held.
//    in_ready=0 throughout; a second in_valid is accepted only after the handshake.
//  5 rst_n=0 while in SYND of a 1-error frame -> next cycle in_ready=1, out_valid=0, no result emitted.
//  6 LDPC_DEC_STATS_EN: three frames, the third with MAX_ITER failure forced -> stat_frames=3, stat_fails=1.
//    Build without the macro and confirm the ports are absent.

Source files
------------

// File: rtl/ldpc_dec_pkg.sv
// Base matrix and derived sizes for the team's quasi-cyclic LDPC code, shared by the
// bit-flipping decoder and its syndrome/unsatisfied-check network.
package ldpc_dec_pkg;

  localparam int NB       = 4;
  localparam int MB       = 2;
  localparam int ZERO_BLK = -1;
  localparam int UNSAT_W  = $clog2(MB + 1);

  // Row 0 is all-identity, row 1 uses distinct shifts so no 4-cycles appear (girth >= 6).
  localparam int SHIFT [MB][NB] = '{'{0, 0, 0, 0}, '{0, 1, 2, 3}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYND,
    ST_EVAL,
    ST_DONE
  } dec_state_t;

  function automatic int n_of(input int z);
    return NB * z;
  endfunction

  function automatic int m_of(input int z);
    return MB * z;
  endfunction

  function automatic int k_of(input int z);
    return (NB - MB) * z;
  endfunction

endpackage

// File: rtl/ldpc_syndrome_calc.sv
// Combinational parity-check network: syndrome of a codeword and, for every bit,
// the number of unsatisfied checks it participates in. Fully driven by SHIFT.
module ldpc_syndrome_calc
  import ldpc_dec_pkg::*;
#(
  parameter int Z = 8,
  localparam int N = n_of(Z),
  localparam int M = m_of(Z),
  localparam int UW = UNSAT_W
) (
  input  logic [N-1:0]    cw,
  output logic [M-1:0]    syndrome,
  output logic [N*UW-1:0] unsat
);

  always_comb begin
    syndrome = '0;
    for (int r = 0; r < MB; r++) begin
      for (int b = 0; b < NB; b++) begin
        if (SHIFT[r][b] != ZERO_BLK) begin
          for (int i = 0; i < Z; i++) begin
            syndrome[r*Z+i] = syndrome[r*Z+i] ^ cw[b*Z + ((i + SHIFT[r][b]) % Z)];
          end
        end
      end
    end
  end

  always_comb begin
    unsat = '0;
    for (int r = 0; r < MB; r++) begin
      for (int b = 0; b < NB; b++) begin
        if (SHIFT[r][b] != ZERO_BLK) begin
          for (int i = 0; i < Z; i++) begin
            unsat[(b*Z + ((i + SHIFT[r][b]) % Z))*UW +: UW] =
              unsat[(b*Z + ((i + SHIFT[r][b]) % Z))*UW +: UW] + {{(UW-1){1'b0}}, syndrome[r*Z+i]};
          end
        end
      end
    end
  end

endmodule

// File: rtl/ldpc_bf_decoder.sv
// Hard-decision bit-flipping LDPC decoder: syndrome/flip iterations until clean or MAX_ITER.
// Optional frame/failure counters are built when LDPC_DEC_STATS_EN is defined.
module ldpc_bf_decoder
  import ldpc_dec_pkg::*;
#(
  parameter int Z        = 8,
  parameter int MAX_ITER = 16,
  parameter int ITW      = 5,
  localparam int N  = n_of(Z),
  localparam int M  = m_of(Z),
  localparam int K  = k_of(Z),
  localparam int UW = UNSAT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   c,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [K-1:0]   s,
  output logic           dec_ok,
  output logic [ITW-1:0] iter_used
`ifdef LDPC_DEC_STATS_EN
  ,
  output logic [15:0]    stat_frames,
  output logic [15:0]    stat_fails
`endif
);

  dec_state_t          state, state_nxt;
  logic [N-1:0]        cw_reg;
  logic [N-1:0]        flip_mask;
  logic [M-1:0]        syn_reg;
  logic [M-1:0]        syndrome;
  logic [N*UW-1:0]     unsat;
  logic [UW-1:0]       umax;
  logic [ITW-1:0]      iter;
  logic                syn_zero;
  logic                at_max;

  function automatic logic [UW-1:0] max_unsat(input logic [N*UW-1:0] u);
    logic [UW-1:0] m;
    m = '0;
    for (int j = 0; j < N; j++) begin
      if (u[j*UW +: UW] > m) m = u[j*UW +: UW];
    end
    return m;
  endfunction

  ldpc_syndrome_calc #(.Z(Z)) u_synd (
    .cw       (cw_reg),
    .syndrome (syndrome),
    .unsat    (unsat)
  );

  assign syn_zero = (syn_reg == '0);
  assign at_max   = (iter == ITW'(MAX_ITER));

  // In EVAL cw_reg is unchanged since SYND, so unsat matches syn_reg.
  always_comb begin
    flip_mask = '0;
    umax      = max_unsat(unsat);
    for (int j = 0; j < N; j++) begin
      flip_mask[j] = (unsat[j*UW +: UW] == umax);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_SYND;
      end
      ST_SYND: state_nxt = ST_EVAL;
      ST_EVAL: state_nxt = (syn_zero || at_max) ? ST_DONE : ST_SYND;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      syn_reg   <= '0;
      s         <= '0;
      dec_ok    <= 1'b0;
      iter_used <= '0;
    end else begin
      if (state == ST_SYND) syn_reg <= syndrome;
      if (state == ST_EVAL && (syn_zero || at_max)) begin
        s         <= cw_reg[N-1 -: K];
        dec_ok    <= syn_zero;
        iter_used <= iter;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && in_valid) begin
      cw_reg <= c;
      iter   <= '0;
    end else if (state == ST_EVAL && !syn_zero && !at_max) begin
      cw_reg <= cw_reg ^ flip_mask;
      iter   <= iter + 1'b1;
    end
  end

`ifdef LDPC_DEC_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_frames <= '0;
      stat_fails  <= '0;
    end else if (out_valid && out_ready) begin
      stat_frames <= stat_frames + 16'd1;
      if (!dec_ok) stat_fails <= stat_fails + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ldpc_bf_decoder.sv
// Directed bench for ldpc_bf_decoder: one default instance and one with MAX_ITER=0.
module tb_ldpc_bf_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] c;
  logic        in_valid_a, in_valid_b;
  logic        in_ready_a, in_ready_b;
  logic        out_valid_a, out_valid_b;
  logic        out_ready_a, out_ready_b;
  logic [15:0] s_a, s_b;
  logic        dec_ok_a, dec_ok_b;
  logic [4:0]  iter_used_a, iter_used_b;
`ifdef LDPC_DEC_STATS_EN
  logic [15:0] stat_frames_a, stat_fails_a, stat_frames_b, stat_fails_b;
`endif

  logic        sel;
  logic        ir, ov, ok;
  logic [15:0] sv;
  logic [4:0]  it;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ldpc_bf_decoder #(.Z(8), .MAX_ITER(16), .ITW(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a), .c(c),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .s(s_a), .dec_ok(dec_ok_a),
    .iter_used(iter_used_a)
`ifdef LDPC_DEC_STATS_EN
    , .stat_frames(stat_frames_a), .stat_fails(stat_fails_a)
`endif
  );

  ldpc_bf_decoder #(.Z(8), .MAX_ITER(0), .ITW(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .c(c),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .s(s_b), .dec_ok(dec_ok_b),
    .iter_used(iter_used_b)
`ifdef LDPC_DEC_STATS_EN
    , .stat_frames(stat_frames_b), .stat_fails(stat_fails_b)
`endif
  );

  assign ir = sel ? in_ready_b  : in_ready_a;
  assign ov = sel ? out_valid_b : out_valid_a;
  assign sv = sel ? s_b         : s_a;
  assign ok = sel ? dec_ok_b    : dec_ok_a;
  assign it = sel ? iter_used_b : iter_used_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one codeword on the selected instance and wait for its result (no handshake).
  task automatic run_frame(input string tag, input logic [31:0] cw, input int exp_lat,
                           input logic [15:0] exp_s, input logic exp_ok, input logic [4:0] exp_it);
    int k;
    int lat;
    k = 0;
    while (!ir && k < 20) begin
      step();
      k++;
    end
    chk({tag, " in_ready"}, ir, 1);
    c = cw;
    if (sel) in_valid_b = 1'b1;
    else     in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    lat = 0;
    while (!ov && lat < 200) begin
      step();
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " s"}, sv, exp_s);
    chk({tag, " dec_ok"}, ok, exp_ok);
    chk({tag, " iter_used"}, it, exp_it);
  endtask

  initial begin
    int seen;
    sel = 1'b0;
    rst_n = 1'b0;
    c = '0;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    out_ready_a = 1'b1;
    out_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", in_ready_a, 1);
    chk("rst out_valid", out_valid_a, 0);
    chk("rst s", s_a, 16'h0000);
    chk("rst dec_ok", dec_ok_a, 0);
    chk("rst iter_used", iter_used_a, 0);
`ifdef LDPC_DEC_STATS_EN
    chk("rst stat_frames", stat_frames_a, 0);
    chk("rst stat_fails", stat_fails_a, 0);
`endif
    rst_n = 1'b1;
    step();

    // Clean all-zero frame.
    run_frame("t1", 32'h0000_0000, 2, 16'h0000, 1'b1, 5'd0);
    step();
    chk("t1 out_valid after hs", out_valid_a, 0);

    // Single error at bit 5: one flip.
    run_frame("t2", 32'h0000_0020, 4, 16'h0000, 1'b1, 5'd1);
    step();

    // All-ones codeword with bit 26 flipped, result held with out_ready low.
    out_ready_a = 1'b0;
    run_frame("t4", 32'hFBFF_FFFF, 4, 16'hFFFF, 1'b1, 5'd1);
    c = 32'h0000_0000;
    in_valid_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4 hold out_valid", out_valid_a, 1);
      chk("t4 hold s", s_a, 16'hFFFF);
      chk("t4 hold dec_ok", dec_ok_a, 1);
      chk("t4 hold in_ready", in_ready_a, 0);
    end
    out_ready_a = 1'b1;
    step();
    chk("t4 hs out_valid", out_valid_a, 0);
    chk("t4 hs in_ready", in_ready_a, 1);
    chk("t4 idle holds s", s_a, 16'hFFFF);
    step();
    in_valid_a = 1'b0;
    chk("t4 second accepted", in_ready_a, 0);
    step();
    step();
    chk("t4 second out_valid", out_valid_a, 1);
    chk("t4 second s", s_a, 16'h0000);
    chk("t4 second iter_used", iter_used_a, 0);
    step();

    // Reset while the frame sits in SYND.
    c = 32'h0000_0020;
    in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    chk("t5 in SYND", in_ready_a, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5 in_ready", in_ready_a, 1);
    chk("t5 out_valid", out_valid_a, 0);
    chk("t5 dec_ok cleared", dec_ok_a, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid_a) seen++;
    end
    chk("t5 no output", seen, 0);

    // MAX_ITER=0 instance: raw bits returned on failure, then two clean frames.
    sel = 1'b1;
    run_frame("t3", 32'h0001_0000, 2, 16'h0001, 1'b0, 5'd0);
    step();
    run_frame("t6a", 32'hFFFF_FFFF, 2, 16'hFFFF, 1'b1, 5'd0);
    step();
    run_frame("t6b", 32'h0000_0000, 2, 16'h0000, 1'b1, 5'd0);
    step();
`ifdef LDPC_DEC_STATS_EN
    chk("t6 stat_frames", stat_frames_b, 3);
    chk("t6 stat_fails", stat_fails_b, 1);
    chk("t6 stat_frames_a", stat_frames_a, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
